sd_frame_seq: RTL and testbench



---
 rtl/sd_pkg.sv | 36 +++
 rtl/sd_frame_seq_if.sv | 33 +++
 rtl/sd_op_issuer.sv | 89 ++++++++
 rtl/sd_frame_seq.sv | 165 ++++++++++++++++
 tb/tb_sd_frame_seq.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD frame-fetch sequencer:
// frame geometry, SD op-select encoding and FSM state types.
package sd_pkg;

   localparam int BLOCKS_PER_FRAME = 300;
   localparam int ACK_TIMEOUT      = 8;

   typedef enum logic [2:0] {
      OP_NONE = 3'b000,
      OP_INIT = 3'b001,
      OP_READ = 3'b010,
      OP_STRM = 3'b100
   } sd_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_CMD,
      S_SINKW,
      S_STRM,
      S_DONE,
      S_ERR
   } seq_state_e;

   typedef enum logic [1:0] {
      I_IDLE,
      I_SETUP,
      I_ACK,
      I_WAIT
   } iss_state_e;

   function automatic logic is_last_blk(input logic [8:0] cnt);
      return cnt == 9'(BLOCKS_PER_FRAME - 1);
   endfunction

endpackage

// File: rtl/sd_frame_seq_if.sv
// Op-select / kick handshake between the frame sequencer
// (master) and the SD card interface (slave).
interface sd_frame_seq_if;

   logic       sd_init;
   logic       sd_read_cmd;
   logic       sd_stream_512B;
   logic       sd_end_of_frame;
   logic [3:0] sd_img_id;
   logic       sd_if_begin;
   logic       sd_if_busy;

   modport master (
      output sd_init,
      output sd_read_cmd,
      output sd_stream_512B,
      output sd_end_of_frame,
      output sd_img_id,
      output sd_if_begin,
      input  sd_if_busy
   );

   modport slave (
      input  sd_init,
      input  sd_read_cmd,
      input  sd_stream_512B,
      input  sd_end_of_frame,
      input  sd_img_id,
      input  sd_if_begin,
      output sd_if_busy
   );

endinterface

// File: rtl/sd_op_issuer.sv
// One SD operation: SETUP (op line held), KICK, ACK with
// timeout, WAIT for busy low, then release the op line.
module sd_op_issuer
   import sd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req_i,
   input  sd_op_e     op_i,
   input  logic       eof_i,
   input  logic       if_busy_i,
   output logic [2:0] op_o,
   output logic       eof_o,
   output logic       if_begin_o,
   output logic       op_done_o,
   output logic       op_err_o
);

   localparam logic [3:0] TMR_LAST = 4'(ACK_TIMEOUT - 1);

   iss_state_e st_q;
   sd_op_e     op_q;
   logic       eof_q;
   logic       begin_q;
   logic [3:0] tmr_q;
   logic       fin;
   logic       tmo;

   // completion and timeout are seen on the edge that retires the op
   assign fin = (st_q == I_WAIT) && !if_busy_i;
   assign tmo = (st_q == I_ACK) && !if_busy_i
                && (tmr_q == TMR_LAST);

   assign op_o       = op_q;
   assign eof_o      = eof_q;
   assign if_begin_o = begin_q;
   assign op_done_o  = fin;
   assign op_err_o   = tmo;

   // handshake FSM; op lines and kick are registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q    <= I_IDLE;
         op_q    <= OP_NONE;
         eof_q   <= 1'b0;
         begin_q <= 1'b0;
         tmr_q   <= '0;
      end else begin
         begin_q <= 1'b0;
         case (st_q)
            I_IDLE: begin
               if (req_i) begin
                  op_q  <= op_i;
                  eof_q <= eof_i;
                  st_q  <= I_SETUP;
               end
            end
            I_SETUP: begin
               // a stale busy from the card holds off the kick
               if (!if_busy_i) begin
                  begin_q <= 1'b1;
                  tmr_q   <= '0;
                  st_q    <= I_ACK;
               end
            end
            I_ACK: begin
               if (if_busy_i) begin
                  st_q <= I_WAIT;
               end else if (tmo) begin
                  op_q  <= OP_NONE;
                  eof_q <= 1'b0;
                  st_q  <= I_IDLE;
               end else begin
                  tmr_q <= tmr_q + 4'd1;
               end
            end
            I_WAIT: begin
               if (fin) begin
                  op_q  <= OP_NONE;
                  eof_q <= 1'b0;
                  st_q  <= I_IDLE;
               end
            end
            default: st_q <= I_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/sd_frame_seq.sv
// Frame-fetch sequencer: init once, then read/stream pairs
// for every block of the selected image, paced by the sink.
module sd_frame_seq
   import sd_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [3:0]     img_sel,
   input  logic           sink_ready,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic [8:0]     blk_cnt,
   sd_frame_seq_if.master sd
);

   seq_state_e st_q;
   logic       busy_q;
   logic       done_q;
   logic       err_q;
   logic [8:0] blk_q;
   logic [3:0] img_q;
   logic       inited_q;
   logic       issued_q;

   logic       req;
   sd_op_e     req_op;
   logic       req_eof;
   logic [2:0] op_lines;
   logic       eof_line;
   logic       kick;
   logic       op_done;
   logic       op_err;

   // op request is combinational so SETUP follows the deciding edge
   always_comb begin
      req     = 1'b0;
      req_op  = OP_NONE;
      req_eof = 1'b0;
      case (st_q)
         S_IDLE: begin
            if (start) begin
               req    = 1'b1;
               req_op = inited_q ? OP_READ : OP_INIT;
            end
         end
         S_CMD: begin
            if (!issued_q) begin
               req    = 1'b1;
               req_op = OP_READ;
            end
         end
         S_SINKW: begin
            if (sink_ready) begin
               req     = 1'b1;
               req_op  = OP_STRM;
               req_eof = is_last_blk(blk_q);
            end
         end
         default: ;
      endcase
   end

   sd_op_issuer u_iss (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req),
      .op_i       (req_op),
      .eof_i      (req_eof),
      .if_busy_i  (sd.sd_if_busy),
      .op_o       (op_lines),
      .eof_o      (eof_line),
      .if_begin_o (kick),
      .op_done_o  (op_done),
      .op_err_o   (op_err)
   );

   // frame sequencing; a started frame only ends via DONE or ERR
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q     <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         blk_q    <= '0;
         img_q    <= '0;
         inited_q <= 1'b0;
         issued_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (op_err) begin
            err_q    <= 1'b1;
            inited_q <= 1'b0;
            st_q     <= S_ERR;
         end else begin
            case (st_q)
               S_IDLE: begin
                  if (start) begin
                     img_q    <= img_sel;
                     blk_q    <= '0;
                     busy_q   <= 1'b1;
                     issued_q <= 1'b1;
                     st_q     <= inited_q ? S_CMD : S_INIT;
                  end
               end
               S_INIT: begin
                  if (op_done) begin
                     inited_q <= 1'b1;
                     issued_q <= 1'b0;
                     st_q     <= S_CMD;
                  end
               end
               S_CMD: begin
                  if (!issued_q) begin
                     issued_q <= 1'b1;
                  end else if (op_done) begin
                     st_q <= S_SINKW;
                  end
               end
               S_SINKW: begin
                  if (sink_ready) begin
                     st_q <= S_STRM;
                  end
               end
               S_STRM: begin
                  if (op_done) begin
                     blk_q <= blk_q + 9'd1;
                     if (is_last_blk(blk_q)) begin
                        done_q <= 1'b1;
                        st_q   <= S_DONE;
                     end else begin
                        issued_q <= 1'b0;
                        st_q     <= S_CMD;
                     end
                  end
               end
               S_DONE: begin
                  busy_q <= 1'b0;
                  st_q   <= S_IDLE;
               end
               S_ERR: begin
                  busy_q <= 1'b0;
                  st_q   <= S_IDLE;
               end
               default: st_q <= S_IDLE;
            endcase
         end
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign blk_cnt = blk_q;

   assign sd.sd_init         = op_lines[0];
   assign sd.sd_read_cmd     = op_lines[1];
   assign sd.sd_stream_512B  = op_lines[2];
   assign sd.sd_end_of_frame = eof_line;
   assign sd.sd_img_id       = img_q;
   assign sd.sd_if_begin     = kick;

endmodule

// File: tb/tb_sd_frame_seq.sv
// Scoreboard bench for sd_frame_seq with a randomized SD card
// model and a frame-level reference of the expected op stream.
module tb_sd_frame_seq;
   import sd_pkg::*;

   typedef struct packed {
      logic [2:0] op;
      logic       eof;
      logic [3:0] img;
   } op_t;

   typedef struct {
      int kind;
      int blk;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] img_sel = 4'd0;
   logic       sink_ready = 1'b1;
   logic       busy;
   logic       done;
   logic       err;
   logic [8:0] blk_cnt;

   sd_frame_seq_if sd_bus ();

   sd_frame_seq dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .img_sel    (img_sel),
      .sink_ready (sink_ready),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .blk_cnt    (blk_cnt),
      .sd         (sd_bus)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad = 0;
   op_t  exp_ops[$];
   ev_t  exp_ev[$];
   bit   m_inited = 0;
   bit   fail_read = 0;
   int   sd_st = 0;
   int   sd_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, expv);
      end
   endtask

   // reference: what one accepted start must produce at the SD side
   function automatic void push_frame(input logic [3:0] img,
                                      input bit fail);
      op_t o;
      ev_t e;
      if (!m_inited) begin
         o = '{op: OP_INIT, eof: 1'b0, img: img};
         exp_ops.push_back(o);
      end
      if (fail) begin
         o = '{op: OP_READ, eof: 1'b0, img: img};
         exp_ops.push_back(o);
         e = '{kind: 2, blk: 0};
         exp_ev.push_back(e);
         m_inited = 0;
         return;
      end
      m_inited = 1;
      for (int b = 0; b < BLOCKS_PER_FRAME; b++) begin
         o = '{op: OP_READ, eof: 1'b0, img: img};
         exp_ops.push_back(o);
         o = '{op: OP_STRM, eof: (b == BLOCKS_PER_FRAME - 1),
               img: img};
         exp_ops.push_back(o);
      end
      e = '{kind: 1, blk: BLOCKS_PER_FRAME};
      exp_ev.push_back(e);
   endfunction

   // SD card model: random ack delay and busy length per kick
   always @(negedge clk) begin
      if (rst) begin
         sd_bus.sd_if_busy = 1'b0;
         sd_st = 0;
      end else begin
         case (sd_st)
            0: begin
               if (sd_bus.sd_if_begin &&
                   !(fail_read && sd_bus.sd_read_cmd)) begin
                  sd_cnt = int'($urandom_range(0, 2));
                  if (sd_cnt == 0) begin
                     sd_bus.sd_if_busy = 1'b1;
                     sd_cnt = int'($urandom_range(1, 4));
                     sd_st = 2;
                  end else begin
                     sd_st = 1;
                  end
               end
            end
            1: begin
               sd_cnt--;
               if (sd_cnt == 0) begin
                  sd_bus.sd_if_busy = 1'b1;
                  sd_cnt = int'($urandom_range(1, 4));
                  sd_st = 2;
               end
            end
            2: begin
               sd_cnt--;
               if (sd_cnt == 0) begin
                  sd_bus.sd_if_busy = 1'b0;
                  sd_st = 0;
               end
            end
            default: sd_st = 0;
         endcase
      end
   end

   // monitor: pop expected kicks and frame endings as they appear
   always @(negedge clk) begin
      op_t o;
      ev_t e;
      int  kind;
      if (!rst) begin
         if (sd_bus.sd_if_begin) begin
            if (exp_ops.size() == 0) begin
               chk("unexp_kick", 32'(1), 32'(0));
            end else begin
               o = exp_ops.pop_front();
               chk("kick_op", 32'({sd_bus.sd_stream_512B,
                                   sd_bus.sd_read_cmd,
                                   sd_bus.sd_init}), 32'(o.op));
               chk("kick_eof", 32'(sd_bus.sd_end_of_frame),
                   32'(o.eof));
               chk("kick_img", 32'(sd_bus.sd_img_id), 32'(o.img));
            end
         end
         if (done || err) begin
            kind = done ? 1 : 2;
            if (exp_ev.size() == 0) begin
               chk("unexp_end", 32'(kind), 32'(0));
            end else begin
               e = exp_ev.pop_front();
               chk("end_kind", 32'(kind), 32'(e.kind));
               if (done) chk("end_blk", 32'(blk_cnt), 32'(e.blk));
            end
         end
      end
   end

   task automatic kick_start(input logic [3:0] img);
      @(negedge clk);
      start = 1'b1;
      img_sel = img;
      @(negedge clk);
      start = 1'b0;
      img_sel = 4'($urandom);
   endtask

   task automatic run_to_end(input int budget, input bit rnd);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rnd) sink_ready = ($urandom_range(0, 3) != 0);
         if (done || err) begin
            seen = 1;
            break;
         end
      end
      sink_ready = 1'b1;
      chk("end_in_budget", 32'(seen), 32'(1));
      if (seen) begin
         chk("busy_at_end", 32'(busy), 32'(1));
         @(negedge clk);
         chk("busy_drop", 32'({busy, done}), 32'(0));
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cnt;
      int  hold;
      bit  got;

      repeat (3) @(negedge clk);
      chk("reset_outs",
          32'({busy, done, err, blk_cnt, sd_bus.sd_init,
               sd_bus.sd_read_cmd, sd_bus.sd_stream_512B,
               sd_bus.sd_end_of_frame, sd_bus.sd_img_id,
               sd_bus.sd_if_begin}), 32'(0));
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // cold start: init then 300 read/stream pairs
      push_frame(4'd3, 0);
      kick_start(4'd3);
      run_to_end(12000, 0);

      // warm start: read command first, kick at cycle 2
      push_frame(4'd5, 0);
      kick_start(4'd5);
      chk("warm_rd_c1", 32'({sd_bus.sd_read_cmd,
                             sd_bus.sd_if_begin}), 32'(2));
      @(negedge clk);
      chk("warm_kick_c2", 32'({sd_bus.sd_read_cmd,
                               sd_bus.sd_if_begin}), 32'(3));
      run_to_end(12000, 0);
      chk("warm_img", 32'(sd_bus.sd_img_id), 32'(5));

      // sink hold before block 10, then ignored mid-frame start
      push_frame(4'd9, 0);
      kick_start(4'd9);
      cnt = 0;
      got = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (sd_bus.sd_if_begin && sd_bus.sd_read_cmd) cnt++;
         if (cnt == 11) begin
            got = 1;
            break;
         end
      end
      chk("reach_rd10", 32'(got), 32'(1));
      sink_ready = 1'b0;
      hold = 0;
      repeat (50) begin
         @(negedge clk);
         if (sd_bus.sd_if_begin && sd_bus.sd_stream_512B) hold++;
      end
      chk("hold_no_strm", 32'(hold), 32'(0));
      sink_ready = 1'b1;
      @(negedge clk);
      chk("sink_kick_r1", 32'(sd_bus.sd_if_begin), 32'(0));
      @(negedge clk);
      chk("sink_kick_r2", 32'({sd_bus.sd_if_begin,
                               sd_bus.sd_stream_512B}), 32'(3));
      chk("blk10_cnt", 32'(blk_cnt), 32'(10));
      repeat (100) @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      img_sel = 4'd7;
      @(negedge clk);
      start = 1'b0;
      chk("ign_start_img", 32'(sd_bus.sd_img_id), 32'(9));
      chk("ign_start_busy", 32'(busy), 32'(1));
      run_to_end(12000, 0);
      chk("ign_end_img", 32'(sd_bus.sd_img_id), 32'(9));
      repeat (20) @(negedge clk);

      // read command never acknowledged
      fail_read = 1;
      push_frame(4'd2, 1);
      kick_start(4'd2);
      @(negedge clk);
      chk("to_kick", 32'({sd_bus.sd_if_begin,
                          sd_bus.sd_read_cmd}), 32'(3));
      hold = 0;
      repeat (7) begin
         @(negedge clk);
         if (err) hold++;
      end
      chk("to_early", 32'(hold), 32'(0));
      @(negedge clk);
      chk("to_err", 32'(err), 32'(1));
      chk("to_ops", 32'({sd_bus.sd_init, sd_bus.sd_read_cmd,
                         sd_bus.sd_stream_512B,
                         sd_bus.sd_end_of_frame}), 32'(0));
      @(negedge clk);
      chk("to_busy", 32'({busy, err}), 32'(0));
      fail_read = 0;

      // re-init after error, random sink pacing
      push_frame(4'd6, 0);
      kick_start(4'd6);
      run_to_end(20000, 1);

      // reset during block 150 stream
      push_frame(4'd12, 0);
      kick_start(4'd12);
      cnt = 0;
      got = 0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (sd_bus.sd_if_begin && sd_bus.sd_stream_512B) cnt++;
         if (cnt == 151) begin
            got = 1;
            break;
         end
      end
      chk("reach_blk150", 32'(got), 32'(1));
      chk("blk150_cnt", 32'(blk_cnt), 32'(150));
      rst = 1'b1;
      #1;
      chk("rst_outs",
          32'({busy, done, err, blk_cnt, sd_bus.sd_init,
               sd_bus.sd_read_cmd, sd_bus.sd_stream_512B,
               sd_bus.sd_end_of_frame, sd_bus.sd_img_id,
               sd_bus.sd_if_begin}), 32'(0));
      exp_ops.delete();
      exp_ev.delete();
      m_inited = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // after reset the next frame starts with init again
      push_frame(4'd1, 0);
      kick_start(4'd1);
      run_to_end(12000, 0);

      repeat (10) @(negedge clk);
      chk("ops_drained", 32'(exp_ops.size()), 32'(0));
      chk("ev_drained", 32'(exp_ev.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
